// File: rtl/bsg_gateway_iodelay_input_ctrl.sv
// bsg_gateway_iodelay_input_ctrl: programs the input IODELAY chain from a runtime tap table
//   clk_i / reset_i (async, active-low)
//   start_i, tap_i                  : reprogram request and target tap table (line k at [k*tap_width_p +: tap_width_p])
//   ready_o / busy_o / done_o       : handshake status
//   iodelay_rst_o / iodelay_inc_o / iodelay_ce_o : delay element controls
//   line_o                          : line currently being programmed
module bsg_gateway_iodelay_input_ctrl #(
    parameter int lines_p     = 40,
    parameter int tap_width_p = 8,
    parameter int max_tap_p   = 31,
    parameter int settle_p    = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           start_i,
    input  logic [lines_p*tap_width_p-1:0] tap_i,
    output logic                           ready_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           iodelay_rst_o,
    output logic                           iodelay_inc_o,
    output logic [lines_p-1:0]             iodelay_ce_o,
    output logic [$clog2(lines_p)-1:0]     line_o
);
    localparam int LW = $clog2(lines_p);
    localparam int CW = $clog2(max_tap_p + 1);
    localparam int SW = $clog2(settle_p + 1);

    typedef enum logic [2:0] {IDLE, RST, SETTLE, STEP, DONE} state_e;

    state_e            state_q, state_d;
    logic [LW-1:0]     line_q, line_d, nxt_line;
    logic [CW-1:0]     cnt_q, cnt_d, cur_t, nxt_t, first_t;
    logic [SW-1:0]     set_q, set_d;
    logic [lines_p-1:0] ce_q, ce_d;
    logic [CW-1:0]     snap_q [lines_p];

    // Clamped snapshot; it only feeds datapath decisions, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && start_i)
            for (int k = 0; k < lines_p; k++)
                snap_q[k] <= (tap_i[k*tap_width_p +: tap_width_p] > tap_width_p'(max_tap_p))
                           ? CW'(max_tap_p) : tap_i[k*tap_width_p +: CW];
    end

    assign nxt_line = line_q + 1'b1;
    assign cur_t    = snap_q[line_q];
    assign nxt_t    = snap_q[nxt_line];
    assign first_t  = snap_q[0];

    // Entering a line with a nonzero target issues its first CE immediately,
    // so the counter is preloaded to 1 alongside that CE.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        cnt_d   = cnt_q;
        set_d   = set_q;
        ce_d    = '0;
        case (state_q)
            IDLE: if (start_i) state_d = RST;
            RST: begin
                state_d = SETTLE;
                line_d  = '0;
                cnt_d   = '0;
                set_d   = '0;
            end
            SETTLE: begin
                set_d = set_q + 1'b1;
                if (set_q == SW'(settle_p - 1)) begin
                    state_d = STEP;
                    line_d  = '0;
                    cnt_d   = CW'(|first_t);
                    ce_d    = (|first_t) ? lines_p'(1) : '0;
                end
            end
            STEP: begin
                if (|ce_q) begin
                    // gap cycle follows every CE
                end else if (cur_t != '0 && cnt_q != cur_t) begin
                    ce_d  = lines_p'(1) << line_q;
                    cnt_d = cnt_q + 1'b1;
                end else if (line_q == LW'(lines_p - 1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    line_d = nxt_line;
                    cnt_d  = CW'(|nxt_t);
                    ce_d   = (|nxt_t) ? lines_p'(1) << nxt_line : '0;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= IDLE;
            line_q        <= '0;
            cnt_q         <= '0;
            set_q         <= '0;
            ce_q          <= '0;
            ready_o       <= 1'b1;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            iodelay_rst_o <= 1'b0;
            iodelay_inc_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            cnt_q         <= cnt_d;
            set_q         <= set_d;
            ce_q          <= ce_d;
            ready_o       <= state_d == IDLE;
            busy_o        <= state_d != IDLE;
            done_o        <= state_d == DONE;
            iodelay_rst_o <= state_d == RST;
            iodelay_inc_o <= state_d == STEP;
        end
    end

    assign iodelay_ce_o = ce_q;
    assign line_o       = line_q;
endmodule

// File: tb/tb_bsg_gateway_iodelay_input_ctrl.sv
// tb_bsg_gateway_iodelay_input_ctrl: cycle-accurate check of the input IODELAY controller against a trace model
module tb_bsg_gateway_iodelay_input_ctrl;
    localparam int L = 4;
    localparam int S = 4;

    logic           clk_i = 1'b0;
    logic           reset_i = 1'b0;
    logic           start_i = 1'b0;
    logic [L*8-1:0] tap_i = '0;
    logic           ready_o, busy_o, done_o, iodelay_rst_o, iodelay_inc_o;
    logic [L-1:0]   iodelay_ce_o;
    logic [1:0]     line_o;
    logic [L-1:0]   prev_ce = '0;
    int             n_cmp = 0;
    int             n_bad = 0;

    bsg_gateway_iodelay_input_ctrl #(.lines_p(L), .tap_width_p(8), .max_tap_p(31), .settle_p(S)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .tap_i(tap_i),
        .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
        .iodelay_rst_o(iodelay_rst_o), .iodelay_inc_o(iodelay_inc_o),
        .iodelay_ce_o(iodelay_ce_o), .line_o(line_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected trace entry: {ready,busy,done,rst,inc, ce[3:0], line (STEP only)}
    task automatic run(input logic [31:0] taps, input int disturb, input int abort);
        logic [10:0] q[$];
        logic [10:0] o;
        int c;
        q.push_back(11'b0_1_0_1_0_0000_00);
        repeat (S) q.push_back(11'b0_1_0_0_0_0000_00);
        for (int k = 0; k < L; k++) begin
            c = (taps[k*8 +: 8] > 8'd31) ? 31 : int'(taps[k*8 +: 8]);
            if (c == 0) q.push_back({9'b0_1_0_0_1_0000, 2'(k)});
            for (int j = 0; j < c; j++) begin
                q.push_back({5'b0_1_0_0_1, 4'(1 << k), 2'(k)});
                q.push_back({9'b0_1_0_0_1_0000, 2'(k)});
            end
        end
        q.push_back(11'b0_1_1_0_0_0000_00);
        q.push_back(11'b1_0_0_0_0_0000_00);
        tap_i   = taps;
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        prev_ce = '0;
        for (int i = 0; i < q.size(); i++) begin
            o = {ready_o, busy_o, done_o, iodelay_rst_o, iodelay_inc_o, iodelay_ce_o,
                 iodelay_inc_o ? line_o : 2'b00};
            chk($sformatf("trace[%0d]", i), 32'(o), 32'(q[i]));
            chk("ce_onehot0", 32'($onehot0(iodelay_ce_o)), 32'd1);
            chk("ce_back_to_back", 32'((|prev_ce) && (|iodelay_ce_o)), 32'd0);
            chk("ce_without_inc", 32'((|iodelay_ce_o) && !iodelay_inc_o), 32'd0);
            prev_ce = iodelay_ce_o;
            if (i == abort) begin
                reset_i = 1'b0;
                #1;
                chk("abort_state", 32'({ready_o, busy_o, done_o, iodelay_rst_o, iodelay_inc_o, iodelay_ce_o, line_o}),
                    32'(11'b1_0_0_0_0_0000_00));
                #2 reset_i = 1'b1;
                return;
            end
            if (i == disturb) begin
                start_i = 1'b1;
                tap_i   = $urandom;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        logic [31:0] r;
        #12;
        chk("reset_state", 32'({ready_o, busy_o, done_o, iodelay_rst_o, iodelay_inc_o, iodelay_ce_o, line_o}),
            32'(11'b1_0_0_0_0_0000_00));
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;
        run(32'h00_00_00_00, -1, -1);
        run(32'h03_00_02_01, -1, -1);
        run(32'h00_00_00_FF, -1, -1);
        run(32'h02_01_03_02, 8, -1);
        run(32'h00_00_03_01, -1, 7);
        run(32'h00_00_03_01, -1, -1);
        repeat (6) begin
            r = {8'($urandom_range(40, 0)), 8'($urandom_range(40, 0)),
                 8'($urandom_range(40, 0)), 8'($urandom_range(40, 0))};
            run(r, -1, -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
